// File: rtl/fe_redirect_ctrl.sv
// fe_redirect_ctrl: fetch PC owner that freezes on decoded control transfers and redirects on AGEX resolution
module fe_redirect_ctrl #(
  parameter int DBITS = 32,
  parameter logic [DBITS-1:0] START_PC = 32'h0000_0200,
  parameter int CNTBITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               de_stall,
  input  logic               de_br_detect,
  input  logic               agex_br_valid,
  input  logic               agex_br_taken,
  input  logic [DBITS-1:0]   agex_br_target,
  output logic [DBITS-1:0]   pc,
  output logic [DBITS-1:0]   pcplus,
  output logic               fe_valid,
  output logic [DBITS-1:0]   inst_count,
  output logic [CNTBITS-1:0] br_taken_cnt,
  output logic               align_err
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  state_t state, state_nx;
  logic redirect, taken, advance, seq;
  // state register; reset always lands in BOOT so a pending resolution is dropped
  always_ff @(posedge clk)
    if (!reset) state <= BOOT;
    else state <= state_nx;
  // next state: a resolution in RUN or HOLD always returns to RUN, an accepted branch parks in HOLD
  always_comb begin
    state_nx = state == BOOT ? RUN
             : state == RUN  ? (!agex_br_valid && !de_stall && de_br_detect ? HOLD : RUN)
             : state == HOLD ? (agex_br_valid ? RUN : HOLD)
             : BOOT;
  end
  // outputs and datapath enables; BOOT ignores AGEX entirely
  always_comb begin
    fe_valid = state == RUN;
    pcplus   = pc + DBITS'(4);
    redirect = agex_br_valid && (state == RUN || state == HOLD);
    taken    = redirect && agex_br_taken;
    advance  = state == RUN && !agex_br_valid && !de_stall;
    seq      = advance && !de_br_detect;
  end
  // pc and counters; pc already holds the fall-through when a branch is accepted
  always_ff @(posedge clk)
    if (!reset) begin
      pc           <= START_PC;
      inst_count   <= '0;
      br_taken_cnt <= '0;
      align_err    <= 1'b0;
    end else begin
      if (taken) pc <= {agex_br_target[DBITS-1:2], 2'b00};
      else if (seq) pc <= pcplus;
      if (advance) inst_count <= inst_count + DBITS'(1);
      if (taken) br_taken_cnt <= br_taken_cnt + CNTBITS'(1);
      if (taken && agex_br_target[1:0] != 2'b00) align_err <= 1'b1;
    end
endmodule

// File: doc/fe_redirect_ctrl.md
# fe_redirect_ctrl

- Fetch-side PC and redirect controller; it is the receiving end of the `from_AGEX_to_FE` branch-resolution bundle.
- It owns the architectural fetch PC and advances it sequentially. It freezes fetch while a decoded control-transfer instruction is unresolved, then redirects or resumes in the cycle after AGEX resolves it.
- It sits in FE, between the instruction-memory address port and the FE→DE latch.

## Interface
Parameters:
- DBITS, 32, PC/data width
- START_PC, 32'h0000_0200, PC value loaded by reset
- CNTBITS, 16, width of taken-branch counter

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk only)
- de_stall  in  1  DE cannot accept a new instruction this cycle
- de_br_detect  in  1  instruction currently in DE is BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR
- agex_br_valid  in  1  AGEX holds a control-transfer instruction this cycle (is_branch)
- agex_br_taken  in  1  branch condition satisfied (br_cond); JAL/JALR always 1
- agex_br_target  in  DBITS  resolved target address
- pc  out  DBITS  current fetch address (registered)
- pcplus  out  DBITS  pc + 4 (combinational from pc)
- fe_valid  out  1  instruction at pc is valid for DE
- inst_count  out  DBITS  count of instructions handed to DE
- br_taken_cnt  out  CNTBITS  count of taken redirects; wraps modulo 2^CNTBITS
- align_err  out  1  sticky: a redirect target had target[1:0] != 0

## Operation
States:
- BOOT: entered on reset.
  - fe_valid=0.
  - Unconditionally → RUN next cycle.
- RUN: fe_valid=1.
  - **agex_br_valid=1** (out-of-protocol redirect): handled exactly as in HOLD. It has priority over all other RUN actions.
  - **de_stall=1**: pc holds, inst_count holds, state stays RUN. de_br_detect is ignored, because the branch stays in DE and is re-presented.
  - **de_stall=0, de_br_detect=0**: pc ← pc+4, inst_count+1.
  - **de_stall=0, de_br_detect=1**:
    - inst_count+1.
    - pc holds; it already equals branch PC+4, the fall-through.
    - → HOLD.
- HOLD: fe_valid=0.
  - pc and inst_count frozen.
  - de_stall and de_br_detect are ignored.
  - Waits for agex_br_valid.
    - **Taken**:
      - pc ← {agex_br_target[DBITS-1:2], 2'b00}.
      - br_taken_cnt+1.
      - If agex_br_target[1:0] != 0, align_err ← 1.
      - → RUN.
    - **Not taken**: pc unchanged → RUN.
- Reset values (after any cycle with reset=0):
  - state=BOOT, pc=START_PC, pcplus=START_PC+4.
  - fe_valid=0, inst_count=0, br_taken_cnt=0, align_err=0.
- Arithmetic:
  - pc+4 wraps modulo 2^DBITS.
  - inst_count and br_taken_cnt wrap silently.
  - align_err clears only on reset.
- fe_valid is decoded from the state register only; it has no combinational path from inputs.
- agex_br_taken and agex_br_target are ignored when agex_br_valid=0.

## Timing
- Sequential fetch: one instruction per cycle while RUN and de_stall=0.
- Branch penalty:
  - de_br_detect accepted at cycle N → fe_valid=0 from N+1.
  - agex_br_valid at cycle M → pc=target (or fall-through) and fe_valid=1 at M+1.
  - Normal back-to-back pipeline: M=N+1, giving exactly one bubble.
- Redirect latency from agex_br_valid to the new pc visible: 1 cycle.
- Simultaneous events:
  - agex_br_valid with de_stall in RUN: redirect wins.
  - agex_br_valid with de_br_detect in HOLD: redirect, → RUN. The DE instruction is squashed by DE itself; this block does not re-enter HOLD for it.
- Reset mid-HOLD: pending resolution is discarded. Next cycle is BOOT with pc=START_PC; an agex_br_valid arriving in BOOT is ignored.
- BOOT lasts exactly one cycle after reset deasserts.

## Test plan
- **Reset and boot**: hold reset=0 for 3 cycles, release.
  - Expect pc=0x200 and fe_valid=0 for the first post-reset cycle, then fe_valid=1.
  - Then pc=0x204, 0x208, 0x20C on successive cycles; inst_count=3.
- **Stall**: in RUN at pc=0x210, de_stall=1 for 2 cycles.
  - Expect pc stays 0x210 and inst_count frozen; pc=0x214 one cycle after release.
- **Taken branch**: de_br_detect at pc=0x220; next cycle agex_br_valid=1, taken=1, target=0x300.
  - Expect one cycle fe_valid=0, then pc=0x300, fe_valid=1, br_taken_cnt=1.
- **Not-taken branch**: same stimulus with taken=0.
  - Expect one bubble, then pc=0x220, fe_valid=1, br_taken_cnt unchanged.
- **Misaligned target**: JALR resolves taken with target=0x402.
  - Expect pc=0x400 and align_err=1.
  - align_err remains 1 through later branches until reset=0.
- **Reset mid-HOLD**: enter HOLD, assert reset=0 in the same cycle as agex_br_valid (target 0x500).
  - Expect pc=0x200, state BOOT, fe_valid=0, br_taken_cnt=0; target 0x500 is never loaded.
